// File: rtl/y86_dmem.sv
// y86_dmem: data-memory responder for the Y86-64 SEQ core.
//
// It serves one 64-bit load or store at a time. Accesses are byte-addressed
// and little-endian. An unaligned address touches two consecutive storage
// words. An address whose 8-byte span runs past the end of storage (or past
// 2^64) produces an error response, which the core reports as status ADR.
//
// Parameters
//   DEPTH_WORDS  number of 64-bit storage words (byte capacity = DEPTH_WORDS*8)
//   LATENCY      extra wait cycles per word access (0..7)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept a request (high only in IDLE)
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data, little-endian
//   rsp_valid  response present
//   rsp_ready  core accepts response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_error  address out of range
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high
// ACC0  | accessing word w = addr>>3 (1+LATENCY cycles)
// ACC1  | accessing word w+1 for unaligned requests (1+LATENCY cycles)
// RESP  | response held on rsp_* until rsp_ready
module y86_dmem #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [64:0] BYTE_CAP = 65'(DEPTH_WORDS) * 65'd8;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} stateT;

  stateT        state;
  logic         capWrite;
  logic [AW-1:0] capWord;
  logic [2:0]   capOff;
  logic [63:0]  capWdata;
  logic [2:0]   waitCnt;
  logic [63:0]  loWord;

  logic [63:0]  mem [DEPTH_WORDS];

  logic [64:0]  lastByte;
  logic         addrErr;
  logic         accept;
  logic         accDone;
  logic         lastAcc;
  logic [AW-1:0] capWordNext;
  logic [63:0]  rdWord;
  logic [5:0]   byteShift;
  logic [6:0]   hiShift;
  logic [63:0]  loadData;
  logic [63:0]  storeLo;
  logic [63:0]  storeHi;

  // Address of the last byte touched, computed one bit wider so that an
  // address above 2^64-8 lands at or above 2^64 and is always rejected.
  assign lastByte = {1'b0, req_addr} + 65'd7;
  assign addrErr  = (lastByte >= BYTE_CAP);

  assign accept      = req_valid && req_ready;
  assign accDone     = ((state == ACC0) || (state == ACC1)) && (waitCnt == 3'd0);
  assign lastAcc     = accDone && ((state == ACC1) || (capOff == 3'd0));
  assign capWordNext = capWord + AW'(1);

  // Single read port: ACC0 reads word w, ACC1 reads word w+1.
  assign rdWord    = mem[(state == ACC1) ? capWordNext : capWord];
  assign byteShift = {capOff, 3'b000};
  assign hiShift   = 7'd64 - {1'b0, byteShift};

  // loWord holds word w (latched at the end of ACC0) when the access is unaligned.
  assign loadData = (capOff == 3'd0) ? rdWord
                                     : ((loWord >> byteShift) | (rdWord << hiShift));

  // Store data lined up for each word: bytes o..7 of w and bytes 0..o-1 of w+1.
  assign storeLo = capWdata << byteShift;
  assign storeHi = capWdata >> hiShift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      capWrite  <= 1'b0;
      capWord   <= '0;
      capOff    <= '0;
      capWdata  <= '0;
      waitCnt   <= '0;
      loWord    <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            capWrite  <= req_write;
            capWord   <= req_addr[AW+2:3];
            capOff    <= req_addr[2:0];
            capWdata  <= req_wdata;
            waitCnt   <= 3'(LATENCY);
            if (addrErr) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= ACC0;
            end
          end
        end
        ACC0: begin
          if (waitCnt != 3'd0) begin
            waitCnt <= waitCnt - 3'd1;
          end else if (capOff == 3'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= capWrite ? 64'd0 : loadData;
          end else begin
            loWord  <= rdWord;
            waitCnt <= 3'(LATENCY);
            state   <= ACC1;
          end
        end
        ACC1: begin
          if (waitCnt != 3'd0) begin
            waitCnt <= waitCnt - 3'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= capWrite ? 64'd0 : loadData;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset. All bytes of a store land on the edge that leaves
  // the final ACC state; a reset before that edge puts the FSM in IDLE and
  // nothing is written.
  always_ff @(posedge clk) begin
    if (lastAcc && capWrite) begin
      for (int b = 0; b < 8; b++) begin
        if (3'(b) >= capOff) begin
          mem[capWord][8*b +: 8] <= storeLo[8*b +: 8];
        end else begin
          mem[capWordNext][8*b +: 8] <= storeHi[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_y86_dmem.sv
module tb_y86_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;          // 0: LATENCY=0 instance, 1: LATENCY=3 instance
  logic        reqValid, reqWrite, rspReady;
  logic [63:0] reqAddr, reqWdata;

  logic        vld0, vld1, rr0, rr1;
  logic        rdy0, rdy1, rv0, rv1, re0, re1;
  logic [63:0] rd0, rd1;

  assign vld0 = reqValid & ~sel;
  assign vld1 = reqValid & sel;
  assign rr0  = rspReady & ~sel;
  assign rr1  = rspReady & sel;

  y86_dmem #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(vld0), .req_ready(rdy0), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_error(re0)
  );

  y86_dmem #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(vld1), .req_ready(rdy1), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_error(re1)
  );

  int tests = 0;
  int fails = 0;

  // Reference memory: a plain byte array per instance.
  logic [7:0] mb [2][2048];

  function automatic logic curRdy();
    return sel ? rdy1 : rdy0;
  endfunction
  function automatic logic curRv();
    return sel ? rv1 : rv0;
  endfunction
  function automatic logic curRe();
    return sel ? re1 : re0;
  endfunction
  function automatic logic [63:0] curRd();
    return sel ? rd1 : rd0;
  endfunction
  function automatic int latOf();
    return sel ? 3 : 0;
  endfunction

  function automatic logic mErr(input logic [63:0] a);
    return (a > 64'hFFFF_FFFF_FFFF_FFF8) || ((a + 64'd7) >= 64'd2048);
  endfunction

  function automatic logic [63:0] mLoad(input int d, input logic [63:0] a);
    logic [63:0] v;
    int base;
    v = '0;
    if (!mErr(a)) begin
      base = int'(a[10:0]);
      for (int i = 0; i < 8; i++) v[8*i +: 8] = mb[d][base + i];
    end
    return v;
  endfunction

  task automatic mStore(input int d, input logic [63:0] a, input logic [63:0] wd);
    int base;
    if (!mErr(a)) begin
      base = int'(a[10:0]);
      for (int i = 0; i < 8; i++) mb[d][base + i] = wd[8*i +: 8];
    end
  endtask

  function automatic int expCyc(input logic [63:0] a);
    if (mErr(a)) return 0;
    return ((a[2:0] == 3'd0) ? 1 : 2) * (1 + latOf());
  endfunction

  // Issue one request on the selected instance; returns the response fields
  // and the number of edges from acceptance to rsp_valid. Leaves RESP pending.
  task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                     input logic early, output logic [63:0] rdata,
                     output logic err, output int cyc);
    int n;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqWdata = wd; rspReady = early;
    n = 0;
    while (!curRdy() && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL accept_timeout addr=%h ready stayed %b", a, curRdy());
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWrite = 1'($urandom_range(0, 1));
    reqAddr  = {$urandom, $urandom};
    reqWdata = {$urandom, $urandom};
    cyc = 0;
    while (!curRv() && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 100) begin
      tests++; fails++;
      $display("FAIL response_timeout addr=%h rsp_valid stayed %b", a, curRv());
    end
    rdata = curRd();
    err   = curRe();
  endtask

  task automatic respond();
    @(negedge clk);
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h40; reqWdata = {$urandom, $urandom};
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({rdy0, rdy1, rv0, rv1, re0, re1} !== 6'b0 || rd0 !== 64'd0 || rd1 !== 64'd0) begin
        fails++;
        $display("FAIL reset_outputs got rdy=%b%b rv=%b%b err=%b%b rd0=%h expected all 0",
                 rdy0, rdy1, rv0, rv1, re0, re1, rd0);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %b expected 1", rdy0);
    end
    reqValid = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (rv0 !== 1'b0 || rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_no_accept got rv=%b rdy=%b expected rv=0 rdy=1", rv0, rdy0);
    end
  endtask

  task automatic test_init();
    logic [63:0] rd;
    logic er;
    int cyc;
    int errs;
    errs = 0;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int w = 0; w < 256; w++) begin
        txn(1'b1, 64'(w) * 64'd8, 64'd0, 1'b1, rd, er, cyc);
        if (er !== 1'b0 || rd !== 64'd0) errs++;
        mStore(d, 64'(w) * 64'd8, 64'd0);
        respond();
      end
    end
    sel = 1'b0;
    tests++;
    if (errs !== 0) begin
      fails++;
      $display("FAIL init_stores got %0d bad responses expected 0", errs);
    end
  endtask

  task automatic test_aligned();
    logic [63:0] rd;
    logic er;
    int cyc;
    sel = 1'b0;
    txn(1'b1, 64'h40, 64'h1122_3344_5566_7788, 1'b0, rd, er, cyc);
    mStore(0, 64'h40, 64'h1122_3344_5566_7788);
    tests++;
    if (cyc !== 1 || er !== 1'b0 || rd !== 64'd0) begin
      fails++;
      $display("FAIL aligned_store got cyc=%0d err=%b rd=%h expected cyc=1 err=0 rd=0", cyc, er, rd);
    end
    respond();
    txn(1'b0, 64'h40, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (cyc !== 1 || er !== 1'b0 || rd !== 64'h1122_3344_5566_7788) begin
      fails++;
      $display("FAIL aligned_load got cyc=%0d err=%b rd=%h expected cyc=1 err=0 rd=1122334455667788",
               cyc, er, rd);
    end
    respond();
  endtask

  task automatic test_unaligned();
    logic [63:0] rd;
    logic er;
    int cyc;
    sel = 1'b0;
    txn(1'b1, 64'h10, 64'd0, 1'b1, rd, er, cyc); mStore(0, 64'h10, 64'd0); respond();
    txn(1'b1, 64'h18, 64'd0, 1'b1, rd, er, cyc); mStore(0, 64'h18, 64'd0); respond();
    txn(1'b1, 64'h13, 64'hAABB_CCDD_EEFF_0011, 1'b0, rd, er, cyc);
    mStore(0, 64'h13, 64'hAABB_CCDD_EEFF_0011);
    tests++;
    if (cyc !== 2 || er !== 1'b0 || rd !== 64'd0) begin
      fails++;
      $display("FAIL unaligned_store got cyc=%0d err=%b rd=%h expected cyc=2 err=0 rd=0", cyc, er, rd);
    end
    respond();
    txn(1'b0, 64'h10, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (rd !== 64'hDDEE_FF00_1100_0000 || cyc !== 1) begin
      fails++;
      $display("FAIL unaligned_load_lo got rd=%h cyc=%0d expected rd=ddeeff0011000000 cyc=1", rd, cyc);
    end
    respond();
    txn(1'b0, 64'h18, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (rd !== 64'h0000_0000_00AA_BBCC) begin
      fails++;
      $display("FAIL unaligned_load_hi got rd=%h expected 0000000000aabbcc", rd);
    end
    respond();
    txn(1'b0, 64'h13, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (rd !== 64'hAABB_CCDD_EEFF_0011 || cyc !== 2 || er !== 1'b0) begin
      fails++;
      $display("FAIL unaligned_load_full got rd=%h cyc=%0d err=%b expected aabbccddeeff0011 cyc=2 err=0",
               rd, cyc, er);
    end
    respond();
  endtask

  task automatic test_range();
    logic [63:0] rd;
    logic er;
    int cyc;
    sel = 1'b0;
    txn(1'b0, 64'h7F8, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (er !== 1'b0 || cyc !== 1 || rd !== mLoad(0, 64'h7F8)) begin
      fails++;
      $display("FAIL range_top_ok got err=%b cyc=%0d rd=%h expected err=0 cyc=1 rd=%h",
               er, cyc, rd, mLoad(0, 64'h7F8));
    end
    respond();
    txn(1'b0, 64'h7F9, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (er !== 1'b1 || cyc !== 0 || rd !== 64'd0) begin
      fails++;
      $display("FAIL range_over got err=%b cyc=%0d rd=%h expected err=1 cyc=0 rd=0", er, cyc, rd);
    end
    respond();
    txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, rd, er, cyc);
    tests++;
    if (er !== 1'b1 || cyc !== 0 || rd !== 64'd0) begin
      fails++;
      $display("FAIL range_wrap_store got err=%b cyc=%0d rd=%h expected err=1 cyc=0 rd=0", er, cyc, rd);
    end
    respond();
    txn(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, rd, er, cyc);
    tests++;
    if (er !== 1'b1 || rd !== 64'd0) begin
      fails++;
      $display("FAIL range_top_addr got err=%b rd=%h expected err=1 rd=0", er, rd);
    end
    respond();
    txn(1'b0, 64'h0, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (er !== 1'b0 || rd !== mLoad(0, 64'h0)) begin
      fails++;
      $display("FAIL range_word0_intact got err=%b rd=%h expected err=0 rd=%h", er, rd, mLoad(0, 64'h0));
    end
    respond();
  endtask

  task automatic test_backpressure();
    logic [63:0] rd;
    logic er;
    int cyc;
    logic [63:0] v;
    sel = 1'b1;
    v = 64'h0123_4567_89AB_CDEF;
    txn(1'b1, 64'h100, v, 1'b1, rd, er, cyc);
    mStore(1, 64'h100, v);
    tests++;
    if (cyc !== 4 || er !== 1'b0) begin
      fails++;
      $display("FAIL bp_store_latency got cyc=%0d err=%b expected cyc=4 err=0", cyc, er);
    end
    respond();
    txn(1'b0, 64'h100, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (cyc !== 4 || rd !== v) begin
      fails++;
      $display("FAIL bp_load got cyc=%0d rd=%h expected cyc=4 rd=%h", cyc, rd, v);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h200; reqWdata = 64'hFFFF_0000_FFFF_0000;
      tests++;
      if ({rv1, rdy1, re1} !== 3'b100 || rd1 !== v) begin
        fails++;
        $display("FAIL bp_hold cycle %0d got rv=%b rdy=%b err=%b rd=%h expected rv=1 rdy=0 err=0 rd=%h",
                 k, rv1, rdy1, re1, rd1, v);
      end
    end
    @(negedge clk);
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    tests++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0) begin
      fails++;
      $display("FAIL bp_release got rdy=%b rv=%b expected rdy=1 rv=0", rdy1, rv1);
    end
    txn(1'b0, 64'h200, 64'd0, 1'b1, rd, er, cyc);
    tests++;
    if (rd !== mLoad(1, 64'h200)) begin
      fails++;
      $display("FAIL bp_competing_ignored got rd=%h expected %h", rd, mLoad(1, 64'h200));
    end
    respond();
    txn(1'b0, 64'h103, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (cyc !== 8 || rd !== mLoad(1, 64'h103)) begin
      fails++;
      $display("FAIL bp_unaligned got cyc=%0d rd=%h expected cyc=8 rd=%h", cyc, rd, mLoad(1, 64'h103));
    end
    respond();
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    logic [63:0] rd;
    logic er;
    int cyc;
    int n;
    sel = 1'b0;
    txn(1'b1, 64'h20, 64'd0, 1'b1, rd, er, cyc); mStore(0, 64'h20, 64'd0); respond();
    txn(1'b1, 64'h28, 64'd0, 1'b1, rd, er, cyc); mStore(0, 64'h28, 64'd0); respond();
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 64'h21; reqWdata = '1;
    n = 0;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (rv0 !== 1'b0 || rdy0 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs got rv=%b rdy=%b expected 0 0", rv0, rdy0);
    end
    rst_n = 1'b1;
    txn(1'b0, 64'h20, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (rd !== 64'd0 || er !== 1'b0) begin
      fails++;
      $display("FAIL midreset_word_lo got rd=%h err=%b expected 0 0", rd, er);
    end
    respond();
    txn(1'b0, 64'h28, 64'd0, 1'b0, rd, er, cyc);
    tests++;
    if (rd !== 64'd0 || er !== 1'b0) begin
      fails++;
      $display("FAIL midreset_word_hi got rd=%h err=%b expected 0 0", rd, er);
    end
    respond();
  endtask

  task automatic test_random();
    logic [63:0] rd, a, wd, expD, prevA;
    logic er, wr, early, expE;
    int cyc, eCyc, r;
    prevA = 64'h0;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int i = 0; i < 150; i++) begin
        r = int'($urandom_range(0, 9));
        wr = 1'($urandom_range(0, 1));
        if (r < 6)      a = 64'($urandom_range(0, 2040));
        else if (r < 7) a = 64'($urandom_range(2033, 2060));
        else if (r < 8) a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        else begin
          a  = prevA;
          wr = 1'b0;
        end
        wd    = {$urandom, $urandom};
        early = 1'($urandom_range(0, 1));
        expE  = mErr(a);
        expD  = (wr || expE) ? 64'd0 : mLoad(d, a);
        eCyc  = expCyc(a);
        txn(wr, a, wd, early, rd, er, cyc);
        if (wr) mStore(d, a, wd);
        tests++;
        if (rd !== expD || er !== expE || cyc !== eCyc) begin
          fails++;
          $display("FAIL random inst=%0d wr=%b addr=%h got rd=%h err=%b cyc=%0d expected rd=%h err=%b cyc=%0d",
                   d, wr, a, rd, er, cyc, expD, expE, eCyc);
        end
        respond();
        prevA = a;
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    sel      = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    rspReady = 1'b0;
    #1;
    test_reset();
    test_init();
    test_aligned();
    test_unaligned();
    test_range();
    test_backpressure();
    test_reset_mid_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
